// File: rtl/md_scheduler.sv
// md_scheduler: sequences the shared multiply/divide unit and the HI/LO
// registers. A start in IDLE latches the 64-bit result into pending
// registers, stays busy for a fixed number of cycles and then commits it.
// Optional build macro MD_MADD_EN adds madd/msub on e_op 7 with an e_sub
// select input; without it e_op 7 is a no-op and e_sub does not exist.
module md_scheduler #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        cancel,
    input  logic        d_md_use,
`ifdef MD_MADD_EN
    input  logic        e_sub,
`endif
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_EXT   = 3'd7
    } md_op_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;

    logic signed [63:0] s_prod;
    logic        [63:0] u_prod;
    logic               div_zero;
    logic signed [32:0] s_dvd, s_dvs, s_quo, s_rem;
    logic        [31:0] u_dvs, u_quo, u_rem;
    logic               start;

    // Arithmetic datapath; signed divide runs at 33 bits so -2^31 / -1 cannot overflow.
    always_comb begin
        s_prod   = $signed({{32{e_rs[31]}}, e_rs}) * $signed({{32{e_rt[31]}}, e_rt});
        u_prod   = {32'd0, e_rs} * {32'd0, e_rt};
        div_zero = (e_rt == 32'd0);
        s_dvd    = $signed({e_rs[31], e_rs});
        // Divisor forced to 1 on divide-by-zero; that result is discarded anyway.
        s_dvs    = div_zero ? 33'sd1 : $signed({e_rt[31], e_rt});
        s_quo    = s_dvd / s_dvs;
        s_rem    = s_dvd % s_dvs;
        u_dvs    = div_zero ? 32'd1 : e_rt;
        u_quo    = e_rs / u_dvs;
        u_rem    = e_rs % u_dvs;
    end

    // A start request seen by the hazard unit, independent of the FSM state.
    always_comb begin
        start = 1'b0;
        if (!cancel) begin
            case (md_op_t'(e_op))
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: start = 1'b1;
`ifdef MD_MADD_EN
                OP_EXT:                             start = 1'b1;
`endif
                default:                            start = 1'b0;
            endcase
        end
    end

    assign busy     = (state_q == RUN);
    assign stall_md = d_md_use & (busy | start);
    assign hi       = hi_q;
    assign lo       = lo_q;

    // Next-state logic: accept ops in IDLE, count down and commit in RUN.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        case (state_q)
            IDLE: begin
                if (!cancel) begin
                    case (md_op_t'(e_op))
                        OP_MULT: begin
                            {p_hi_d, p_lo_d} = s_prod;
                            count_d          = MULT_LOAD;
                            state_d          = RUN;
                        end
                        OP_MULTU: begin
                            {p_hi_d, p_lo_d} = u_prod;
                            count_d          = MULT_LOAD;
                            state_d          = RUN;
                        end
                        OP_DIV: begin
                            // Divide-by-zero still takes the full time but leaves HI/LO as they are.
                            if (div_zero) {p_hi_d, p_lo_d} = {hi_q, lo_q};
                            else          {p_hi_d, p_lo_d} = {s_rem[31:0], s_quo[31:0]};
                            count_d = DIV_LOAD;
                            state_d = RUN;
                        end
                        OP_DIVU: begin
                            if (div_zero) {p_hi_d, p_lo_d} = {hi_q, lo_q};
                            else          {p_hi_d, p_lo_d} = {u_rem, u_quo};
                            count_d = DIV_LOAD;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = e_rs;
                        OP_MTLO: lo_d = e_rs;
`ifdef MD_MADD_EN
                        OP_EXT: begin
                            // Accumulate onto HI/LO as they stand at the start edge.
                            if (e_sub) {p_hi_d, p_lo_d} = {hi_q, lo_q} - s_prod;
                            else       {p_hi_d, p_lo_d} = {hi_q, lo_q} + s_prod;
                            count_d = MULT_LOAD;
                            state_d = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Ops and cancel are ignored here: the running op is already committed.
                if (count_q == 4'd1) begin
                    hi_d    = p_hi_q;
                    lo_d    = p_lo_q;
                    count_d = 4'd0;
                    state_d = IDLE;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; reset mid-run drops the pending result.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            p_hi_q  <= 32'd0;
            p_lo_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
        end
    end

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Sequences the shared multiply/divide unit and its HI/LO registers in the 5-stage MIPS pipeline.
- Accepts an MD operation from the E stage and runs it for a fixed multi-cycle latency.
- Commits results to HI/LO and raises a stall request to the hazard unit while D-stage instructions that touch HI/LO must wait.
- Honours the exception/interrupt flush so that a cancelled instruction never starts an operation or writes HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- e_op  input  3  E-stage MD op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- e_rs  input  32  forwarded rs value in E.
- e_rt  input  32  forwarded rt value in E.
- cancel  input  1  exception/eret flush of the E-stage instruction; gates all E-stage effects this cycle.
- d_md_use  input  1  D-stage instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  output  1  operation in progress.
- stall_md  output  1  stall request to hazard unit.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (synchronous, active-high): state IDLE; counter 0; hi, lo, and the pending result registers are 0; busy 0. Reset mid-operation aborts it with no commit.
- States: IDLE and RUN.
- IDLE, e_op in 1..4 and !cancel:
  - Compute the 64-bit result from e_rs/e_rt into pending registers {p_hi, p_lo}.
    - mult: signed 32x32 product, HI = upper 32 bits, LO = lower 32 bits.
    - multu: unsigned 32x32 product, same split.
    - div: signed; LO = quotient, HI = remainder with the sign of the dividend.
    - divu: unsigned; LO = quotient, HI = remainder.
  - Load the counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy = 1 from the next cycle.
- Divide by zero (e_rt == 0): the operation still runs the full DIV_CYCLES; pending = current {hi, lo}, so HI/LO hold their values.
- RUN:
  - The counter decrements every cycle.
  - On the edge where the counter == 1: commit {hi, lo} <= {p_hi, p_lo}, clear the counter, return to IDLE.
  - busy is high for exactly N cycles after the start edge; the new hi/lo are visible in the cycle busy drops.
- mthi / mtlo (e_op 5/6) and !cancel and IDLE: hi or lo <= e_rs at the edge; no busy period.
- Any e_op in 1..6 while RUN is ignored. The hazard unit guarantees this does not occur; the verifier checks it with an assertion.
- cancel while RUN does not abort: the running op belongs to an older, committed instruction.
- cancel in IDLE with e_op != 0: no state change.
- e_op 7: treated as none.
- stall_md = d_md_use & (busy | (e_op in 1..4 & !cancel)). This is combinational, zero latency.
- Back-to-back: a start is accepted in the first IDLE cycle after commit.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined:
  - e_op 7 = madd: signed product of e_rs and e_rt added to {hi, lo} (64-bit, wraps mod 2^64).
  - Latency is MULT_CYCLES; the accumulation uses the {hi, lo} values at start.
  - An extra input e_sub (1 bit) selects msub (subtract) when high.
  - e_op 7 counts as a start for stall_md.
- Undefined: e_op 7 is a no-op, the e_sub port is absent, and no accumulate logic is built.

Test Plan:
- mult: e_rs=0xFFFFFFFE, e_rt=3, one cycle -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall_md=1 throughout when d_md_use=1.
- divu: e_rs=100, e_rt=7 -> busy 10 cycles; lo=14, hi=2.
- div: e_rs=-7 (0xFFFFFFF9), e_rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- div by zero: preload hi=0x11, lo=0x22 via mthi/mtlo; div with e_rt=0 -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- cancel: e_op=1 with cancel=1 -> busy stays 0, stall_md=0. Then cancel=1 during RUN of a prior mult -> result still commits on schedule.
- Reset: assert reset on cycle 3 of a div -> next cycle busy=0, hi=lo=0, no later commit. Also with MD_MADD_EN: hi=0, lo=5, madd 2x3 -> lo=11 after 5 cycles.
